// File: rtl/clawgame_session_ctrl.sv
// clawgame_session_ctrl: sequences one claw-game session.
// The session runs IDLE -> ARMED (countdown) -> PLAYING -> GAME_OVER.
// The block owns the per-game timer and the score counters.
// It also keeps a high score that survives until reset.
// Score strobes from the Arduino count only while PLAYING.
// Optional feature macro: CLAWGAME_BONUS_TIME_EN. When it is defined, every
// 5th accepted score adds 10 s to time_left, capped at GAME_SECONDS.
module clawgame_session_ctrl #(
    parameter int CLK_HZ            = 100000000,
    parameter int GAME_SECONDS      = 60,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int OVER_HOLD_SECONDS = 5,
    parameter int SCORE_W           = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               increment_score,
    input  logic               abort,
    output logic [1:0]         state,
    output logic               game_active,
    output logic               arduino_enable,
    output logic [15:0]        time_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               score_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        PLAYING   = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam int              PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [15:0]     T_COUNT     = 16'(COUNTDOWN_SECONDS);
    localparam logic [15:0]     T_GAME      = 16'(GAME_SECONDS);
    localparam logic [15:0]     T_HOLD_LAST = 16'(OVER_HOLD_SECONDS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t        st;
    logic [PW-1:0] presc;
    logic [15:0]   hold_cnt;
    logic          start_s1, start_s2, start_s3, start_edge;
    logic          inc_s1, inc_s2, inc_s3, inc_edge;
    logic          tick;
    logic          score_accept;
    logic [SCORE_W-1:0] score_next;
    logic [15:0]   play_time_next;
`ifdef CLAWGAME_BONUS_TIME_EN
    logic [2:0]    bonus_cnt;
    logic          bonus_hit;
    logic [16:0]   bonus_sum;
`endif

    assign state        = st;
    assign tick         = (presc == PRESC_LAST);
    assign score_accept = (st == PLAYING) && inc_edge && (score != SCORE_MAX);
    assign score_next   = score_accept ? score + SCORE_W'(1) : score;
`ifdef CLAWGAME_BONUS_TIME_EN
    assign bonus_hit    = score_accept && (bonus_cnt == 3'd4);
`endif

    // Two-flop synchronizers plus registered rising-edge detectors for the async inputs
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {start_s1, start_s2, start_s3, start_edge} <= '0;
            {inc_s1, inc_s2, inc_s3, inc_edge}         <= '0;
        end else begin
            start_s1   <= start_btn;
            start_s2   <= start_s1;
            start_s3   <= start_s2;
            start_edge <= start_s2 & ~start_s3;
            inc_s1     <= increment_score;
            inc_s2     <= inc_s1;
            inc_s3     <= inc_s2;
            inc_edge   <= inc_s2 & ~inc_s3;
        end
    end

    // Play-time update for this cycle: the tick decrement first, then any bonus
    // NOTE: the default is assigned first, so every path drives play_time_next and no latch is inferred.
    always_comb begin
        play_time_next = tick ? time_left - 16'd1 : time_left;
`ifdef CLAWGAME_BONUS_TIME_EN
        bonus_sum = {1'b0, play_time_next} + 17'd10;
        if (bonus_hit) begin
            play_time_next = (bonus_sum > {1'b0, T_GAME}) ? T_GAME : bonus_sum[15:0];
        end
`endif
    end

    // Session FSM with the prescaler, timer, score and high-score registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st             <= IDLE;
            game_active    <= 1'b0;
            arduino_enable <= 1'b0;
            time_left      <= '0;
            score          <= '0;
            high_score     <= '0;
            score_pulse    <= 1'b0;
            presc          <= '0;
            hold_cnt       <= '0;
`ifdef CLAWGAME_BONUS_TIME_EN
            bonus_cnt      <= '0;
`endif
        end else begin
            score_pulse <= 1'b0;
            presc       <= (st == IDLE || tick) ? '0 : presc + PW'(1);

            if (abort) begin
                // Abort wins over start and tick; scores are kept as they are
                st             <= IDLE;
                game_active    <= 1'b0;
                arduino_enable <= 1'b0;
                time_left      <= '0;
                presc          <= '0;
                hold_cnt       <= '0;
            end else if ((st == IDLE || st == GAME_OVER) && start_edge) begin
                score    <= '0;
                presc    <= '0;
                hold_cnt <= '0;
`ifdef CLAWGAME_BONUS_TIME_EN
                bonus_cnt <= '0;
`endif
                if (COUNTDOWN_SECONDS == 0) begin
                    st             <= PLAYING;
                    game_active    <= 1'b1;
                    arduino_enable <= 1'b1;
                    time_left      <= T_GAME;
                end else begin
                    st             <= ARMED;
                    game_active    <= 1'b0;
                    arduino_enable <= 1'b1;
                    time_left      <= T_COUNT;
                end
            end else begin
                case (st)
                    ARMED: begin
                        if (tick) begin
                            if (time_left == 16'd1) begin
                                st          <= PLAYING;
                                game_active <= 1'b1;
                                time_left   <= T_GAME;
                            end else begin
                                time_left <= time_left - 16'd1;
                            end
                        end
                    end
                    PLAYING: begin
                        if (score_accept) begin
                            score       <= score_next;
                            score_pulse <= 1'b1;
`ifdef CLAWGAME_BONUS_TIME_EN
                            bonus_cnt   <= (bonus_cnt == 3'd4) ? 3'd0 : bonus_cnt + 3'd1;
`endif
                        end
                        if (tick && play_time_next == 16'd0) begin
                            // A score landing on the final tick still counts toward the high score
                            st             <= GAME_OVER;
                            game_active    <= 1'b0;
                            arduino_enable <= 1'b0;
                            time_left      <= '0;
                            presc          <= '0;
                            hold_cnt       <= '0;
                            if (score_next > high_score) begin
                                high_score <= score_next;
                            end
                        end else begin
                            time_left <= play_time_next;
                        end
                    end
                    GAME_OVER: begin
                        if (tick) begin
                            if (hold_cnt == T_HOLD_LAST) begin
                                st       <= IDLE;
                                presc    <= '0;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clawgame_session_ctrl.sv
// tb_clawgame_session_ctrl: scoreboard bench for clawgame_session_ctrl.
// A reference model predicts every change of the output vector and the cycle it
// should appear on. A monitor pops those predictions whenever the DUT outputs change.
module tb_clawgame_session_ctrl;

    localparam int CLK_HZ = 10;
    localparam int GAME   = 8;
    localparam int COUNT  = 3;
    localparam int HOLD   = 2;
    localparam int SW     = 3;
    localparam int SMAX   = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_btn = 1'b0;
    logic          inc = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    state;
    logic          game_active, arduino_enable, score_pulse;
    logic [15:0]   time_left;
    logic [SW-1:0] score, high_score;
    logic [31:0]   dut_vec;

    always #5 clk = ~clk;

    clawgame_session_ctrl #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME), .COUNTDOWN_SECONDS(COUNT),
        .OVER_HOLD_SECONDS(HOLD), .SCORE_W(SW)
    ) dut (
        .clock(clk), .reset(rst_n), .start_btn(start_btn), .increment_score(inc),
        .abort(abort), .state(state), .game_active(game_active),
        .arduino_enable(arduino_enable), .time_left(time_left), .score(score),
        .high_score(high_score), .score_pulse(score_pulse)
    );

    assign dut_vec = 32'({state, game_active, arduino_enable, time_left, score, high_score, score_pulse});

    typedef struct {
        logic [31:0] vec;
        int          cyc;
        bit          timed;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ph = 0, m_tl = 0, m_sc = 0, m_hs = 0, m_pulse = 0, m_entry = 0;
    logic [3:0]  sh = '0, ih = '0;
    logic [31:0] m_last = '0;

    function automatic logic [31:0] pack(input int ph, input int tl, input int sc,
                                         input int hs, input int p);
        logic ga, ae;
        ga = (ph == 2);
        ae = (ph == 1 || ph == 2);
        return 32'({2'(ph), ga, ae, 16'(tl), SW'(sc), SW'(hs), p[0]});
    endfunction

    task automatic push_if_changed(input bit timed);
        logic [31:0] v;
        v = pack(m_ph, m_tl, m_sc, m_hs, m_pulse);
        if (v !== m_last) begin
            exp_q.push_back('{vec: v, cyc: cyc, timed: timed});
            m_last = v;
        end
    endtask

    task automatic model_step();
        bit st_ev, sc_ev, tick;
        int el;
        st_ev = sh[2] & ~sh[3];
        sc_ev = ih[2] & ~ih[3];
        el    = cyc - m_entry;
        tick  = (el > 0) && (el % CLK_HZ == 0);
        m_pulse = 0;
        if (abort) begin
            m_ph = 0;
            m_tl = 0;
        end else if ((m_ph == 0 || m_ph == 3) && st_ev) begin
            m_ph = 1; m_entry = cyc; m_tl = COUNT; m_sc = 0;
        end else begin
            case (m_ph)
                1: if (tick) begin
                    m_tl = COUNT - el / CLK_HZ;
                    if (m_tl == 0) begin
                        m_ph = 2; m_entry = cyc; m_tl = GAME;
                    end
                end
                2: begin
                    if (sc_ev && m_sc < SMAX) begin
                        m_sc++;
                        m_pulse = 1;
                    end
                    if (tick) begin
                        m_tl = GAME - el / CLK_HZ;
                        if (m_tl == 0) begin
                            m_ph = 3; m_entry = cyc;
                            if (m_sc > m_hs) m_hs = m_sc;
                        end
                    end
                end
                3: if (el == HOLD * CLK_HZ) m_ph = 0;
                default: ;
            endcase
        end
        sh = {sh[2:0], start_btn};
        ih = {ih[2:0], inc};
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = 0; m_tl = 0; m_sc = 0; m_hs = 0; m_pulse = 0; m_entry = 0;
                sh = '0; ih = '0;
                push_if_changed(1'b0);
            end else begin
                cyc++;
                model_step();
                push_if_changed(1'b1);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] d_last;
        exp_t e;
        d_last = '0;
        forever begin
            @(negedge clk);
            if (dut_vec !== d_last) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", dut_vec, d_last);
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", dut_vec, e.vec);
                    if (e.timed) check("change_cycle", 32'(cyc), 32'(e.cyc));
                end
                d_last = dut_vec;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_start();
        start_btn = 1'b1; cycles(4);
        start_btn = 1'b0; cycles(2);
    endtask

    task automatic score_hit(input int h, input int l);
        inc = 1'b1; cycles(h);
        inc = 1'b0; cycles(l);
    endtask

    task automatic wait_phase(input int p, input int lim);
        int n = 0;
        while (32'(state) != 32'(p) && n < lim) begin
            cycles(1);
            n++;
        end
        check($sformatf("wait_state_%0d", p), 32'(state), 32'(p));
    endtask

    task automatic play(input int n);
        press_start();
        wait_phase(2, 100);
        for (int i = 0; i < n; i++) score_hit($urandom_range(2, 4), $urandom_range(3, 4));
        wait_phase(3, 150);
    endtask

    initial begin
        int target;
        int n;
        #1 rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        check("reset_state", dut_vec, 32'd0);

        // Game 1: three scores plus one landing on the final tick -> high score 4
        press_start();
        score_hit(3, 3);                       // dropped in ARMED
        wait_phase(2, 100);
        for (int i = 0; i < 3; i++) score_hit($urandom_range(2, 4), $urandom_range(3, 4));
        target = m_entry + GAME * CLK_HZ;
        while (cyc < target - 4) cycles(1);
        inc = 1'b1; cycles(3);
        inc = 1'b0;
        wait_phase(3, 20);
        wait_phase(0, 40);

        // Game 2 scores 2; game 3 restarts straight from GAME_OVER and ties at 4
        play(2);
        play(4);
        wait_phase(0, 40);
        // Game 4: nine edges saturate the 3-bit score at 7
        play(9);
        wait_phase(0, 40);

        // Abort mid-play at time_left 3
        press_start();
        wait_phase(2, 100);
        score_hit(3, 3);
        n = 0;
        while (time_left != 16'd3 && n < 100) begin cycles(1); n++; end
        abort = 1'b1; cycles(1);
        abort = 1'b0;
        wait_phase(0, 5);

        // Asynchronous reset between clock edges during play
        press_start();
        wait_phase(2, 100);
        score_hit(2, 3);
        score_hit(2, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_vec, 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Score edges in IDLE and ARMED are ignored, then a full game with no scores
        score_hit(3, 3);
        press_start();
        score_hit(3, 3);
        score_hit(3, 3);
        wait_phase(2, 100);
        wait_phase(3, 150);

        // Random tail
        for (int i = 0; i < 400; i++) begin
            start_btn = ($urandom_range(0, 15) == 0);
            inc       = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 60) == 0);
            cycles(1);
        end
        start_btn = 1'b0; inc = 1'b0; abort = 1'b0;
        cycles(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, expected end before 30000", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clawgame_session_ctrl.md
Name: clawgame_session_ctrl

Overview:
Sequences one claw-game session: idle, pre-game countdown, timed play, game-over hold.
Owns the per-game timer and score counters, and gates score increments from the Arduino so they count only while play is active.
Tracks a session high score.
Outputs feed the LED display controller (time_left, score) and the Arduino (arduino_enable).

Parameters:
CLK_HZ, 100000000, clock cycles per second tick
GAME_SECONDS, 60, play duration loaded into time_left
COUNTDOWN_SECONDS, 3, pre-game countdown length
OVER_HOLD_SECONDS, 5, seconds spent in GAME_OVER before returning to IDLE
SCORE_W, 16, width of score and high_score

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous active-low reset
start_btn  input  1  asynchronous start button, level
increment_score  input  1  asynchronous score strobe from Arduino, level
abort  input  1  synchronous abort request, level
state  output  2  0=IDLE 1=ARMED 2=PLAYING 3=GAME_OVER
game_active  output  1  high only in PLAYING
arduino_enable  output  1  high in ARMED and PLAYING
time_left  output  16  seconds remaining (countdown value in ARMED, play time in PLAYING)
score  output  SCORE_W  current game score
high_score  output  SCORE_W  best score since reset
score_pulse  output  1  one-cycle pulse on each accepted score increment

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, prescaler=0, sync flops=0.
- start_btn and increment_score each pass through a 2-flop synchronizer and a rising-edge detector.
  - Edge pulse is valid 3 cycles after the input rise.
  - A held level produces exactly one pulse.
- Second prescaler: counts 0..CLK_HZ-1. The tick fires on the cycle it wraps. It is cleared on every state entry, so the first tick comes CLK_HZ cycles after entry. It is held at 0 in IDLE.
- IDLE:
  - start edge -> ARMED.
  - score=0 on exit to ARMED. high_score retained.
  - time_left=0.
- ARMED:
  - Entry loads time_left=COUNTDOWN_SECONDS. Each tick decrements it.
  - A tick while time_left==1 -> PLAYING, with time_left loaded to GAME_SECONDS in the same cycle.
  - Score edges are dropped.
- PLAYING:
  - Each tick decrements time_left.
  - A tick while time_left==1 -> GAME_OVER, time_left=0.
  - Score edge: score+1, saturating at all-ones; score_pulse=1 the following cycle. A score edge arriving when saturated gives no pulse.
  - Score edge in the same cycle as the final tick: counted, and included in the high_score compare.
  - start edges are ignored.
- GAME_OVER:
  - On entry, high_score <= score if score > high_score. Ties leave it unchanged.
  - OVER_HOLD_SECONDS ticks -> IDLE. score holds its final value until the next start.
  - start edge -> ARMED immediately, with score cleared.
- abort=1 in any state -> IDLE next cycle. score and high_score are retained; no high_score update.
- abort has priority over start and tick in the same cycle.
- All state transitions and output updates are registered, 1 cycle after the causing event.
- Edge-case parameter: GAME_SECONDS=0 is illegal. COUNTDOWN_SECONDS=0 means the start edge goes directly to PLAYING.

Optional Feature:
CLAWGAME_BONUS_TIME_EN:
- When defined: every 5th accepted score in a game adds 10 s to time_left in PLAYING, capped at GAME_SECONDS. If this coincides with a tick, the decrement applies before the add.
  - Example: time_left=3, tick and 5th score in the same cycle -> time_left=12.
  - A bonus on the final tick cancels the GAME_OVER transition.
- When undefined: no bonus logic; time_left only decrements.

Test Plan:
- CLK_HZ=10, COUNTDOWN=3, GAME=5: start rise -> ARMED 4 cycles later, time_left 3,2,1 every 10 cycles -> PLAYING, time_left=5, game_active=1, arduino_enable=1.
- In PLAYING, 4 increment_score pulses (each high 6 cycles) -> score=4, four 1-cycle score_pulse; at time_left 0 -> GAME_OVER, high_score=4.
- Second game scoring 2 -> high_score stays 4; third game scoring 4 -> unchanged; scoring 7 -> high_score=7.
- SCORE_W=3, 9 edges in PLAYING -> score saturates at 7, only 7 score_pulses.
- Score edge in the same cycle as the final tick -> counted, GAME_OVER with score incremented; abort mid-PLAYING at time_left=3 -> IDLE, high_score unchanged.
- reset low mid-PLAYING (asynchronous, between clock edges) -> all outputs 0 immediately; score edges in IDLE/ARMED are ignored (score stays 0).
